fsm_table: RTL and testbench
============================

FSM_TABLE -- requirements
Module: fsm_table

Interface
REQ-001 Parameter IN_W, default 2, width of state_inputs.
REQ-002 Parameter ST_W, default 3, state register width; N_ST = 2**ST_W states.
REQ-003 Parameter OUT_W, default 4, width of comb_outputs.
REQ-004 Parameter TIMEOUT, default 0, dwell limit in run cycles; 0 disables timeout.
REQ-005 clk  in  1  clock, all state updated on rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-low.
REQ-007 run  in  1  1 = advance FSM this cycle, 0 = hold state and dwell count.
REQ-008 state_inputs  in  IN_W  FSM condition inputs, sampled on clk.
REQ-009 cfg_we_ns  in  1  write next-state table entry.
REQ-010 cfg_we_out  in  1  write output table entry.
REQ-011 cfg_addr  in  ST_W+IN_W  {state, input} for the NS table; bits [ST_W+IN_W-1:IN_W] = state for the OUT table.
REQ-012 cfg_ns  in  ST_W  next-state write data.
REQ-013 cfg_out  in  OUT_W  output write data.
REQ-014 comb_outputs  out  OUT_W  Moore output, out_tbl[cur_state], combinational from registers.
REQ-015 cur_state  out  ST_W  current state register.
REQ-016 state_chg  out  1  registered, 1-cycle pulse when cur_state changed on the previous edge.
REQ-017 timeout  out  1  registered, 1-cycle pulse when a timeout forced the state to 0.

Function
REQ-018 When run=1: next_state = ns_tbl[{cur_state, state_inputs}], loaded on the next edge.
REQ-019 When run=0: cur_state and dwell hold; state_chg and timeout are 0 on the next edge.
REQ-020 Table writes commit on the edge. A same-cycle transition uses the pre-write contents.
REQ-021 cfg_we_ns and cfg_we_out in the same cycle are both performed.
REQ-022 comb_outputs reflects an out_tbl write to the current state from the cycle after the write edge.
REQ-023 dwell counter: clog2(TIMEOUT+1) bits.
  - Increments when run=1 and next_state == cur_state.
  - Clears on any state change.
REQ-024 If TIMEOUT>0, run=1, next_state==cur_state and dwell==TIMEOUT-1:
  - cur_state <= 0, dwell <= 0, timeout <= 1.
  - Timeout overrides the table.
  - timeout pulses even if cur_state is already 0.
REQ-025 state_chg = 1 when the registered state differs from the prior value, including timeout-forced changes.
REQ-026 Next-state result is always within ST_W; no illegal-state recovery is needed beyond the table.

Reset
REQ-027 On reset low, asynchronously:
  - cur_state=0, dwell=0, state_chg=0, timeout=0.
  - All ns_tbl and out_tbl entries = 0.
REQ-028 comb_outputs = 0 during and immediately after reset.
REQ-029 Reset asserted mid-operation aborts any pending write and transition; the table is cleared.

Structure
REQ-030 Package fsm_table_pkg holds:
  - parameter defaults;
  - the NS/OUT address width functions;
  - the dwell width function.
REQ-031 Sub-module fsm_table_mem: a dual-table register file with reset clear and one write port per table, instantiated once.

Verification
REQ-032 Program the legacy 5-state map with outputs 5,8,12,14,9; inputs 00,01,01,10,00 with run=1 -> comb_outputs 5,8,8,12,5.
REQ-033 Legacy map, cur_state=3: hold inputs 11 with run=1 and TIMEOUT=4 -> after 4 cycles cur_state=0, timeout and state_chg pulse once, comb_outputs=5.
REQ-034 Set run=0 for 3 cycles in state 1 with inputs 10 -> cur_state stays 1, no pulses; run=1 -> state 2 next edge.
REQ-035 Write ns_tbl[{1,2'b10}]=4 in the same cycle as a transition from state 1 with input 10 -> old entry used (state 2); a later visit goes to 4.
REQ-036 Assert reset mid-sequence while in state 3 -> cur_state=0 and comb_outputs=0 immediately; all table reads return 0 afterwards.

Source files
------------

// File: rtl/fsm_table_pkg.sv
// fsm_table_pkg: parameter defaults and width helpers shared by the table-driven FSM
package fsm_table_pkg;
  localparam int IN_W_DEF    = 2;
  localparam int ST_W_DEF    = 3;
  localparam int OUT_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 0;
  function automatic int ns_aw(input int st_w, input int in_w);
    return st_w + in_w;
  endfunction
  function automatic int out_aw(input int st_w);
    return st_w;
  endfunction
  // a disabled timeout still needs a 1-bit counter to keep the vector legal
  function automatic int dwell_w(input int timeout);
    return timeout < 1 ? 1 : $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/fsm_table_mem.sv
// fsm_table_mem: next-state and output tables, cleared by reset, one write port each
module fsm_table_mem
  import fsm_table_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ST_W  = ST_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ns_we,
  input  logic [ns_aw(ST_W, IN_W)-1:0]   ns_waddr,
  input  logic [ST_W-1:0]                ns_wdata,
  input  logic                           out_we,
  input  logic [out_aw(ST_W)-1:0]        out_waddr,
  input  logic [OUT_W-1:0]               out_wdata,
  input  logic [ns_aw(ST_W, IN_W)-1:0]   ns_raddr,
  output logic [ST_W-1:0]                ns_rdata,
  input  logic [out_aw(ST_W)-1:0]        out_raddr,
  output logic [OUT_W-1:0]               out_rdata
);
  localparam int NS_N  = 2 ** ns_aw(ST_W, IN_W);
  localparam int OUT_N = 2 ** out_aw(ST_W);
  logic [ST_W-1:0]  ns_tbl  [NS_N];
  logic [OUT_W-1:0] out_tbl [OUT_N];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NS_N; i++) ns_tbl[i] <= '0;
    end else if (ns_we) begin
      ns_tbl[ns_waddr] <= ns_wdata;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < OUT_N; i++) out_tbl[i] <= '0;
    end else if (out_we) begin
      out_tbl[out_waddr] <= out_wdata;
    end
  assign ns_rdata  = ns_tbl[ns_raddr];
  assign out_rdata = out_tbl[out_raddr];
endmodule

// File: rtl/fsm_table.sv
// fsm_table: programmable Moore FSM driven by next-state/output tables with an optional dwell timeout
module fsm_table
  import fsm_table_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int ST_W    = ST_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [IN_W-1:0]       state_inputs,
  input  logic                  cfg_we_ns,
  input  logic                  cfg_we_out,
  input  logic [ST_W+IN_W-1:0]  cfg_addr,
  input  logic [ST_W-1:0]       cfg_ns,
  input  logic [OUT_W-1:0]      cfg_out,
  output logic [OUT_W-1:0]      comb_outputs,
  output logic [ST_W-1:0]       cur_state,
  output logic                  state_chg,
  output logic                  timeout
);
  localparam int DW = dwell_w(TIMEOUT);
  logic [ST_W-1:0] tbl_ns, nxt;
  logic [DW-1:0]   dwell;
  logic            to_hit;
  fsm_table_mem #(.IN_W(IN_W), .ST_W(ST_W), .OUT_W(OUT_W)) u_mem (
    .clk       (clk),
    .reset     (reset),
    .ns_we     (cfg_we_ns),
    .ns_waddr  (cfg_addr),
    .ns_wdata  (cfg_ns),
    .out_we    (cfg_we_out),
    .out_waddr (cfg_addr[ST_W+IN_W-1:IN_W]),
    .out_wdata (cfg_out),
    .ns_raddr  ({cur_state, state_inputs}),
    .ns_rdata  (tbl_ns),
    .out_raddr (cur_state),
    .out_rdata (comb_outputs)
  );
  // the timeout wins over the table, even when the state is already 0
  always_comb begin
    to_hit = TIMEOUT > 0 && run && tbl_ns == cur_state && dwell == DW'(TIMEOUT - 1);
    nxt    = to_hit ? '0 : run ? tbl_ns : cur_state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cur_state <= '0;
      dwell     <= '0;
      state_chg <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cur_state <= nxt;
      dwell     <= (to_hit || nxt != cur_state) ? '0 : run ? dwell + DW'(1) : dwell;
      state_chg <= nxt != cur_state;
      timeout   <= to_hit;
    end
endmodule

// File: tb/tb_fsm_table.sv
// tb_fsm_table: randomized and directed checks of fsm_table against a table-level reference model
module tb_fsm_table;
  localparam int IN_W = 2, ST_W = 3, OUT_W = 4, TIMEOUT = 4;
  logic clk = 0, reset = 0, run = 0;
  logic [IN_W-1:0] state_inputs = '0;
  logic cfg_we_ns = 0, cfg_we_out = 0;
  logic [ST_W+IN_W-1:0] cfg_addr = '0;
  logic [ST_W-1:0] cfg_ns = '0;
  logic [OUT_W-1:0] cfg_out = '0;
  logic [OUT_W-1:0] comb_outputs;
  logic [ST_W-1:0] cur_state;
  logic state_chg, timeout;
  int checks = 0, errors = 0;
  int ns_m [32];
  int out_m [8];
  int m_st, m_dw;
  bit m_chg, m_to;
  // legacy map: row per state, column per input value 0..3
  int legacy_ns [20] = '{0,1,3,0, 0,1,2,4, 0,3,2,2, 0,4,3,3, 0,0,0,0};
  int legacy_out [5] = '{5,8,12,14,9};

  fsm_table #(.IN_W(IN_W), .ST_W(ST_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run), .state_inputs(state_inputs),
    .cfg_we_ns(cfg_we_ns), .cfg_we_out(cfg_we_out), .cfg_addr(cfg_addr),
    .cfg_ns(cfg_ns), .cfg_out(cfg_out), .comb_outputs(comb_outputs),
    .cur_state(cur_state), .state_chg(state_chg), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    foreach (ns_m[i]) ns_m[i] = 0;
    foreach (out_m[i]) out_m[i] = 0;
    m_st = 0; m_dw = 0; m_chg = 0; m_to = 0;
  endtask

  // drive one clock of stimulus and advance the reference model across the edge
  task automatic cycle(input bit r, input int in, input bit wn = 0, input bit wo = 0,
                       input int a = 0, input int d_ns = 0, input int d_out = 0);
    int nsv, nw;
    bit hit;
    run = r; state_inputs = IN_W'(in); cfg_we_ns = wn; cfg_we_out = wo;
    cfg_addr = (ST_W+IN_W)'(a); cfg_ns = ST_W'(d_ns); cfg_out = OUT_W'(d_out);
    @(posedge clk);
    nsv = r ? ns_m[m_st * 4 + in] : m_st;
    hit = r && nsv == m_st && m_dw == TIMEOUT - 1;
    nw = hit ? 0 : nsv;
    m_chg = nw != m_st;
    m_to = hit;
    m_dw = (hit || m_chg) ? 0 : r ? m_dw + 1 : m_dw;
    m_st = nw;
    if (wn) ns_m[a] = d_ns;
    if (wo) out_m[a / 4] = d_out;
    #1;
    cfg_we_ns = 0; cfg_we_out = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({cur_state, comb_outputs, state_chg, timeout} !== '0) begin
      errors++;
      $display("FAIL reset: got st=%0d out=%0d chg=%b to=%b, need all 0", cur_state, comb_outputs, state_chg, timeout);
    end
    #5 reset = 1;
    model_clear();
  endtask

  task automatic program_legacy();
    for (int i = 0; i < 20; i++)
      cycle(0, 0, 1, i % 4 == 0, i, legacy_ns[i], legacy_out[i / 4]);
    checks++;
    if (comb_outputs !== 4'd5 || cur_state !== 0) begin
      errors++;
      $display("FAIL program: got st=%0d out=%0d, need st=0 out=5", cur_state, comb_outputs);
    end
  endtask

  task automatic test_legacy();
    int ins [5] = '{0, 1, 1, 2, 0};
    int exp [5] = '{5, 8, 8, 12, 5};
    for (int k = 0; k < 5; k++) begin
      cycle(1, ins[k]);
      checks++;
      if (comb_outputs !== OUT_W'(exp[k])) begin
        errors++;
        $display("FAIL legacy step %0d: got out=%0d, need %0d", k, comb_outputs, exp[k]);
      end
      checks++;
      if ({cur_state, state_chg, timeout} !== {ST_W'(m_st), m_chg, m_to}) begin
        errors++;
        $display("FAIL legacy state %0d: got st=%0d chg=%b to=%b, need st=%0d chg=%b to=%b",
                 k, cur_state, state_chg, timeout, m_st, m_chg, m_to);
      end
    end
  endtask

  task automatic test_timeout();
    int n_to, n_chg;
    cycle(1, 2);
    checks++;
    if (cur_state !== 3) begin
      errors++;
      $display("FAIL timeout entry: got st=%0d, need 3", cur_state);
    end
    n_to = 0; n_chg = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1, 3);
      n_to += timeout; n_chg += state_chg;
      checks++;
      if ({cur_state, comb_outputs, state_chg, timeout} !== {ST_W'(m_st), OUT_W'(out_m[m_st]), m_chg, m_to}) begin
        errors++;
        $display("FAIL timeout hold %0d: got st=%0d out=%0d chg=%b to=%b, need st=%0d out=%0d chg=%b to=%b",
                 k, cur_state, comb_outputs, state_chg, timeout, m_st, out_m[m_st], m_chg, m_to);
      end
    end
    checks++;
    if (cur_state !== 0 || comb_outputs !== 5 || n_to !== 1 || n_chg !== 1) begin
      errors++;
      $display("FAIL timeout result: got st=%0d out=%0d to_pulses=%0d chg_pulses=%0d, need 0 5 1 1",
               cur_state, comb_outputs, n_to, n_chg);
    end
    n_to = 0; n_chg = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0);
      n_to += timeout; n_chg += state_chg;
    end
    checks++;
    if (cur_state !== 0 || n_to !== 1 || n_chg !== 0 || timeout !== 1) begin
      errors++;
      $display("FAIL timeout in state 0: got st=%0d to_pulses=%0d chg_pulses=%0d last_to=%b, need 0 1 0 1",
               cur_state, n_to, n_chg, timeout);
    end
  endtask

  task automatic test_hold();
    int pulses;
    cycle(1, 1);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 2);
      pulses += state_chg + timeout;
      checks++;
      if (cur_state !== 1) begin
        errors++;
        $display("FAIL hold %0d: got st=%0d, need 1", k, cur_state);
      end
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL hold pulses: got %0d, need 0", pulses);
    end
    cycle(1, 2);
    checks++;
    if (cur_state !== 2 || state_chg !== 1) begin
      errors++;
      $display("FAIL hold release: got st=%0d chg=%b, need st=2 chg=1", cur_state, state_chg);
    end
  endtask

  task automatic test_write_through();
    cycle(1, 0);
    cycle(1, 1);
    cycle(1, 2, 1, 0, 6, 4);
    checks++;
    if (cur_state !== 2) begin
      errors++;
      $display("FAIL write same cycle: got st=%0d, need 2", cur_state);
    end
    cycle(1, 0);
    cycle(1, 1);
    cycle(1, 2);
    checks++;
    if (cur_state !== 4 || comb_outputs !== 9) begin
      errors++;
      $display("FAIL write later visit: got st=%0d out=%0d, need st=4 out=9", cur_state, comb_outputs);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0);
    cycle(1, 2);
    checks++;
    if (cur_state !== 3) begin
      errors++;
      $display("FAIL reset_mid entry: got st=%0d, need 3", cur_state);
    end
    run = 1; state_inputs = 1; cfg_we_ns = 1; cfg_addr = 0; cfg_ns = 5;
    cfg_we_out = 1; cfg_out = 7;
    #2 reset = 0;
    #1;
    checks++;
    if ({cur_state, comb_outputs, state_chg, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_mid async: got st=%0d out=%0d chg=%b to=%b, need all 0", cur_state, comb_outputs, state_chg, timeout);
    end
    @(posedge clk); #2;
    cfg_we_ns = 0; cfg_we_out = 0;
    reset = 1;
    model_clear();
    for (int k = 0; k < 12; k++) begin
      cycle(1, $urandom_range(0, 3));
      checks++;
      if (cur_state !== 0 || comb_outputs !== 0 || timeout !== m_to) begin
        errors++;
        $display("FAIL reset_mid cleared %0d: got st=%0d out=%0d to=%b, need st=0 out=0 to=%b",
                 k, cur_state, comb_outputs, timeout, m_to);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 15));
      checks++;
      if ({cur_state, comb_outputs, state_chg, timeout} !== {ST_W'(m_st), OUT_W'(out_m[m_st]), m_chg, m_to}) begin
        errors++;
        $display("FAIL random %0d: got st=%0d out=%0d chg=%b to=%b, need st=%0d out=%0d chg=%b to=%b",
                 k, cur_state, comb_outputs, state_chg, timeout, m_st, out_m[m_st], m_chg, m_to);
      end
    end
  endtask

  initial begin
    test_reset();
    program_legacy();
    test_legacy();
    test_timeout();
    test_hold();
    test_write_through();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
